// File: rtl/ahb_ext_responder_pkg.sv
// Shared definitions for the external AHB responder: transfer encodings,
// responder state type and the seed of the optional wait-state LFSR.
package ahb_ext_responder_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } resp_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/ahb_ext_responder_if.sv
// AHB-Lite signal bundle between the SoC external port (master side) and the
// external responder (slave side).
interface ahb_ext_responder_if #(
  parameter int AHBW    = 64,
  parameter int PA_BITS = 56
);
  logic                 HSELEXT;
  logic [PA_BITS-1:0]   HADDR;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [1:0]           HTRANS;
  logic                 HREADY;
  logic [AHBW-1:0]      HWDATA;
  logic [AHBW/8-1:0]    HWSTRB;
  logic [AHBW-1:0]      HRDATAEXT;
  logic                 HREADYEXT;
  logic                 HRESPEXT;

  modport master (
    output HSELEXT, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA, HWSTRB,
    input  HRDATAEXT, HREADYEXT, HRESPEXT
  );

  modport slave (
    input  HSELEXT, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA, HWSTRB,
    output HRDATAEXT, HREADYEXT, HRESPEXT
  );
endinterface

// File: rtl/ahb_ext_ram.sv
// Word-organised RAM behind the external window: byte-strobed synchronous
// write port, asynchronous read port. Contents are never reset.
module ahb_ext_ram #(
  parameter int AHBW  = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [AHBW-1:0]          wdata_i,
  input  logic [AHBW/8-1:0]        wstrb_i,
  output logic [AHBW-1:0]          rdata_o
);
  logic [AHBW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < AHBW/8; b++) begin
        if (wstrb_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/ahb_ext_responder.sv
// AHB-Lite subordinate for the SoC external port: RAM-backed window, fixed wait
// states, two-cycle ERROR. Define AHB_EXT_LFSR_WAIT_EN for 0..3 random extra waits.
module ahb_ext_responder
  import ahb_ext_responder_pkg::*;
#(
  parameter int                 AHBW        = 64,
  parameter int                 PA_BITS     = 56,
  parameter int                 DEPTH       = 1024,
  parameter logic [PA_BITS-1:0] BASE        = 'h8000_0000,
  parameter int                 WAIT_CYCLES = 0
) (
  input logic                clk,
  input logic                reset,
  ahb_ext_responder_if.slave bus
);
  localparam int                 BYTEW = $clog2(AHBW/8);
  localparam int                 IDXW  = $clog2(DEPTH);
  localparam int                 CNTW  = 5;
  localparam logic [PA_BITS-1:0] WIN   = PA_BITS'(DEPTH * (AHBW/8));

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_WAIT = ST_WAIT;
  localparam logic [2:0] S_DATA = ST_DATA;
  localparam logic [2:0] S_ERR1 = ST_ERR1;
  localparam logic [2:0] S_ERR2 = ST_ERR2;

  logic [2:0]         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               write_q, write_d;
  logic [PA_BITS-1:0] off;
  logic [CNTW-1:0]    waits;
  logic               open, accept, req_err;
  logic [AHBW-1:0]    ram_rdata;
  logic               unused_ok;

  // A new address phase is only meaningful while we are not stalling the bus.
  assign open    = (state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2);
  assign accept  = open & bus.HSELEXT & bus.HREADY & bus.HTRANS[1];
  assign off     = bus.HADDR - BASE;
  assign req_err = (bus.HADDR < BASE) | (off >= WIN) | (bus.HSIZE > 3'(BYTEW));

`ifdef AHB_EXT_LFSR_WAIT_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lfsr_q <= LFSR_SEED;
    else if (accept) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign waits = CNTW'(WAIT_CYCLES) + CNTW'(lfsr_q[1:0]);
`else
  assign waits = CNTW'(WAIT_CYCLES);
`endif

  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        cnt_d   = cnt_q - CNTW'(1);
        state_d = (cnt_q == CNTW'(1)) ? S_DATA : S_WAIT;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      idx_d   = IDXW'(off >> BYTEW);
      write_d = bus.HWRITE;
      if (req_err) begin
        state_d = S_ERR1;
      end else if (waits != '0) begin
        state_d = S_WAIT;
        cnt_d   = waits;
      end else begin
        state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    write_q <= write_d;
  end

  ahb_ext_ram #(.AHBW(AHBW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    ((state_q == S_DATA) & write_q),
    .idx_i   (idx_q),
    .wdata_i (bus.HWDATA),
    .wstrb_i (bus.HWSTRB),
    .rdata_o (ram_rdata)
  );

  assign bus.HREADYEXT = (state_q != S_WAIT) & (state_q != S_ERR1);
  assign bus.HRESPEXT  = (state_q == S_ERR1) | (state_q == S_ERR2);
  assign bus.HRDATAEXT = ((state_q == S_DATA) & ~write_q) ? ram_rdata : '0;

  // Burst type and the SEQ/NONSEQ distinction do not change the response.
  assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_ext_responder.sv
// Directed bench for ahb_ext_responder: two instances (0 and 3 wait states) share
// one driver; a transfer-level model predicts every output on every cycle.
module tb_ahb_ext_responder;
  import ahb_ext_responder_pkg::*;

  localparam int              AHBW  = 64;
  localparam int              PA    = 56;
  localparam int              DEPTH = 1024;
  localparam logic [PA-1:0]   BASE  = 56'h8000_0000;
  localparam logic [PA-1:0]   WINB  = 56'h2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sel, wr;
  int            tgt;
  logic [PA-1:0] addr;
  logic [2:0]    size;
  logic [1:0]    trans;
  logic [63:0]   wdata;
  logic [7:0]    strb;

  ahb_ext_responder_if #(.AHBW(AHBW), .PA_BITS(PA)) bus0 ();
  ahb_ext_responder_if #(.AHBW(AHBW), .PA_BITS(PA)) bus1 ();

  ahb_ext_responder #(.AHBW(AHBW), .PA_BITS(PA), .DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .reset(rst), .bus(bus0));
  ahb_ext_responder #(.AHBW(AHBW), .PA_BITS(PA), .DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(3))
    dut1 (.clk(clk), .reset(rst), .bus(bus1));

  assign bus0.HSELEXT = sel & (tgt == 0);
  assign bus1.HSELEXT = sel & (tgt == 1);
  assign bus0.HADDR = addr;   assign bus1.HADDR = addr;
  assign bus0.HWRITE = wr;    assign bus1.HWRITE = wr;
  assign bus0.HSIZE = size;   assign bus1.HSIZE = size;
  assign bus0.HBURST = 3'b000; assign bus1.HBURST = 3'b000;
  assign bus0.HTRANS = trans; assign bus1.HTRANS = trans;
  assign bus0.HWDATA = wdata; assign bus1.HWDATA = wdata;
  assign bus0.HWSTRB = strb;  assign bus1.HWSTRB = strb;
  assign bus0.HREADY = bus0.HREADYEXT;
  assign bus1.HREADY = bus1.HREADYEXT;

  logic        rdy [2];
  logic        rsp [2];
  logic [63:0] rd  [2];
  assign rdy[0] = bus0.HREADYEXT; assign rdy[1] = bus1.HREADYEXT;
  assign rsp[0] = bus0.HRESPEXT;  assign rsp[1] = bus1.HRESPEXT;
  assign rd[0]  = bus0.HRDATAEXT; assign rd[1]  = bus1.HRDATAEXT;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted transfer queues the per-cycle responses it will produce.
  typedef struct packed {
    logic       rdy;
    logic       rsp;
    logic       dp;
    logic       wr;
    logic [9:0] idx;
  } ent_t;

  ent_t        fq [2][32];
  int          hd [2] = '{0, 0};
  int          n  [2] = '{0, 0};
  logic [63:0] mem   [2][DEPTH];
  bit          known [2][DEPTH];
  logic [7:0]  lf [2];

  function automatic ent_t mk(input logic r, input logic s, input logic dp, input logic w,
                              input logic [9:0] idx);
    ent_t e;
    e.rdy = r; e.rsp = s; e.dp = dp; e.wr = w; e.idx = idx;
    return e;
  endfunction

  task automatic push(input int d, input ent_t e);
    fq[d][(hd[d] + n[d]) % 32] = e;
    n[d]++;
  endtask

  always @(posedge clk) begin
    bit            open;
    ent_t          e;
    int            w;
    logic [PA-1:0] off;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        n[d]  = 0;
        lf[d] = LFSR_SEED;
      end else begin
        open = (n[d] == 0) || fq[d][hd[d]].rdy;
        if (n[d] != 0) begin
          e = fq[d][hd[d]];
          if (e.dp && e.wr) begin
            for (int b = 0; b < 8; b++)
              if (strb[b]) mem[d][e.idx][8*b +: 8] = wdata[8*b +: 8];
            if (strb == 8'hFF) known[d][e.idx] = 1'b1;
          end
          hd[d] = (hd[d] + 1) % 32;
          n[d]--;
        end
        if (open && sel && tgt == d && trans[1]) begin
          off = addr - BASE;
          w   = (d == 0) ? 0 : 3;
`ifdef AHB_EXT_LFSR_WAIT_EN
          w     += int'(lf[d][1:0]);
          lf[d]  = {lf[d][6:0], ^(lf[d] & 8'hB8)};
`endif
          if (addr < BASE || off >= WINB || size > 3'd3) begin
            push(d, mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0));
            push(d, mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0));
          end else begin
            for (int i = 0; i < w; i++) push(d, mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
            push(d, mk(1'b1, 1'b0, 1'b1, wr, off[12:3]));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        er, es;
    logic [63:0] ed;
    bit          dchk;
    ent_t        e;
    for (int d = 0; d < 2; d++) begin
      er = 1'b1; es = 1'b0; ed = '0; dchk = 1'b1;
      if (!rst && n[d] != 0) begin
        e  = fq[d][hd[d]];
        er = e.rdy;
        es = e.rsp;
        if (e.dp && !e.wr) begin
          ed   = mem[d][e.idx];
          dchk = known[d][e.idx];
        end
      end
      chk($sformatf("model_hready%0d", d), 64'(rdy[d]), 64'(er));
      chk($sformatf("model_hresp%0d", d), 64'(rsp[d]), 64'(es));
      if (dchk) chk($sformatf("model_hrdata%0d", d), rd[d], ed);
    end
  end

  task automatic idle_bus();
    sel   = 1'b0;
    trans = HTRANS_IDLE;
  endtask

  task automatic addr_ph(input int d, input logic [PA-1:0] a, input logic w, input logic [2:0] sz,
                         input logic [1:0] tr, output int k);
    tgt = d; sel = 1'b1; addr = a; wr = w; size = sz; trans = tr;
    k = 0;
    @(negedge clk);
    while (!rdy[d] && k < 40) begin k++; @(negedge clk); end
    chk("addr_phase_timeout", 64'(k < 40), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic data_ph(input int d, input logic [63:0] wd, input logic [7:0] sb,
                         output logic [63:0] rdv, output int lows, output logic rsp0,
                         output logic rspv);
    wdata = wd; strb = sb; lows = 0;
    @(negedge clk);
    rsp0 = rsp[d];
    while (!rdy[d] && lows < 40) begin lows++; @(negedge clk); end
    chk("data_phase_timeout", 64'(lows < 40), 64'd1);
    rdv  = rd[d];
    rspv = rsp[d];
    @(posedge clk); #1;
  endtask

  task automatic xfer(input int d, input logic [PA-1:0] a, input logic w, input logic [2:0] sz,
                      input logic [63:0] wd, input logic [7:0] sb, output logic [63:0] rdv,
                      output int lows, output logic rsp0, output logic rspv);
    int k;
    addr_ph(d, a, w, sz, HTRANS_NONSEQ, k);
    idle_bus();
    data_ph(d, wd, sb, rdv, lows, rsp0, rspv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rv;
    int          lw, k;
    logic        r0, rs;
    int          lfx [3];
`ifdef AHB_EXT_LFSR_WAIT_EN
    lfx = '{1, 2, 1};
`else
    lfx = '{0, 0, 0};
`endif
    rst = 1'b1; sel = 1'b0; tgt = 0; addr = '0; wr = 1'b0; size = 3'd3;
    trans = HTRANS_IDLE; wdata = '0; strb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_hready", 64'(rdy[d]), 64'd1);
      chk("reset_hresp", 64'(rsp[d]), 64'd0);
      chk("reset_hrdata", rd[d], 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // First three transfers after reset: wait counts fixed by the LFSR seed.
    for (int i = 0; i < 3; i++) begin
      xfer(0, BASE + 56'h20 + PA'(8*i), 1'b1, 3'd3, 64'd0, 8'hFF, rv, lw, r0, rs);
      chk($sformatf("lfsr_waits_%0d", i), 64'(lw), 64'(lfx[i]));
    end

    xfer(0, BASE, 1'b1, 3'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF, rv, lw, r0, rs);
    xfer(0, BASE, 1'b0, 3'd3, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("w0_read_data", rv, 64'hDEAD_BEEF_0123_4567);
    chk("w0_read_resp", 64'(rs), 64'd0);
`ifndef AHB_EXT_LFSR_WAIT_EN
    chk("w0_read_waits", 64'(lw), 64'd0);
`endif

    xfer(1, BASE + 56'h8, 1'b1, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, rv, lw, r0, rs);
    xfer(1, BASE + 56'h8, 1'b0, 3'd3, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("w3_read_data", rv, 64'h1122_3344_5566_7788);
    chk("w3_read_resp", 64'(rs), 64'd0);
`ifndef AHB_EXT_LFSR_WAIT_EN
    chk("w3_read_waits", 64'(lw), 64'd3);
`endif

    xfer(0, BASE + 56'h10, 1'b1, 3'd3, 64'd0, 8'hFF, rv, lw, r0, rs);
    xfer(0, BASE + 56'h10, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rv, lw, r0, rs);
    addr_ph(0, BASE + 56'h10, 1'b0, 3'd3, HTRANS_SEQ, k);
    idle_bus();
    data_ph(0, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("strobe_merge", rv, 64'h0000_0000_FFFF_FFFF);

    xfer(0, BASE + WINB, 1'b0, 3'd3, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("oow_read_first_resp", 64'(r0), 64'd1);
    chk("oow_read_low_cycles", 64'(lw), 64'd1);
    chk("oow_read_final_resp", 64'(rs), 64'd1);
    chk("oow_read_data", rv, 64'd0);
    xfer(0, BASE + WINB, 1'b1, 3'd3, 64'h5555_5555_5555_5555, 8'hFF, rv, lw, r0, rs);
    chk("oow_write_resp", 64'(rs), 64'd1);
    xfer(0, BASE, 1'b1, 3'd4, 64'h6666_6666_6666_6666, 8'hFF, rv, lw, r0, rs);
    chk("oversize_write_resp", 64'(rs), 64'd1);
    xfer(0, BASE - 56'h8, 1'b1, 3'd3, 64'h7777_7777_7777_7777, 8'hFF, rv, lw, r0, rs);
    chk("below_base_resp", 64'(rs), 64'd1);
    xfer(0, BASE, 1'b0, 3'd3, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("err_writes_no_effect", rv, 64'hDEAD_BEEF_0123_4567);
    xfer(0, BASE + WINB - 56'h8, 1'b1, 3'd3, 64'h0BAD_CAFE_0000_0001, 8'hFF, rv, lw, r0, rs);
    chk("last_word_write_resp", 64'(rs), 64'd0);
    xfer(0, BASE + WINB - 56'h8, 1'b0, 3'd3, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("last_word_read", rv, 64'h0BAD_CAFE_0000_0001);

    tgt = 0; sel = 1'b1; addr = BASE; wr = 1'b0; trans = HTRANS_BUSY;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy_hready", 64'(rdy[0]), 64'd1);
    chk("busy_hrdata", rd[0], 64'd0);
    @(posedge clk); #1 idle_bus();

    addr_ph(0, BASE + 56'h40, 1'b1, 3'd3, HTRANS_NONSEQ, k);
    wdata = 64'hCAFE_F00D_1234_5678; strb = 8'hFF;
    addr_ph(0, BASE + 56'h40, 1'b0, 3'd3, HTRANS_NONSEQ, k);
`ifndef AHB_EXT_LFSR_WAIT_EN
    chk("b2b_write_stall", 64'(k), 64'd0);
`endif
    idle_bus();
    data_ph(0, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("b2b_read_data", rv, 64'hCAFE_F00D_1234_5678);
`ifndef AHB_EXT_LFSR_WAIT_EN
    chk("b2b_read_stall", 64'(lw), 64'd0);
`endif

    xfer(1, BASE + 56'h48, 1'b1, 3'd3, 64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, rv, lw, r0, rs);
    addr_ph(1, BASE + 56'h48, 1'b1, 3'd3, HTRANS_NONSEQ, k);
    idle_bus();
    wdata = 64'hB2B2_B2B2_B2B2_B2B2; strb = 8'hFF;
    @(negedge clk);
    chk("wait_before_reset", 64'(rdy[1]), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_hready", 64'(rdy[1]), 64'd1);
    chk("mid_reset_hresp", 64'(rsp[1]), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    xfer(1, BASE + 56'h48, 1'b0, 3'd3, 64'd0, 8'h00, rv, lw, r0, rs);
    chk("reset_abandons_write", rv, 64'hA1A1_A1A1_A1A1_A1A1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_ext_responder.md
Name: ahb_ext_responder

Overview:
- Parametrised AHB-Lite subordinate that replaces the fixed tie-off of the SoC external bus port (HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0) in the lint/sim wrapper.
- Backs the external address window with a byte-writable RAM.
- Inserts a configurable number of wait states.
- Returns a two-cycle AHB ERROR for out-of-window or oversized accesses.
- Sits in the testbench wrapper between the wallypipelinedsoc external AHB signals and nothing else.

Parameters:
- AHBW, 64, data bus width in bits (32 or 64).
- PA_BITS, 56, physical address width.
- DEPTH, 1024, RAM words of AHBW bits (power of 2).
- BASE, 'h8000_0000, byte base address of the window (aligned to the window size).
- WAIT_CYCLES, 0, fixed wait states per OKAY data phase (0..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- HSELEXT  in  1  external subordinate select
- HADDR  in  PA_BITS  address-phase address
- HWRITE  in  1  address-phase write
- HSIZE  in  3  address-phase transfer size
- HBURST  in  3  burst type (ignored; each beat treated independently)
- HTRANS  in  2  transfer type
- HREADY  in  1  bus-wide ready (address-phase qualifier)
- HWDATA  in  AHBW  write data (data phase)
- HWSTRB  in  AHBW/8  byte write strobes (data phase)
- HRDATAEXT  out  AHBW  read data
- HREADYEXT  out  1  subordinate ready
- HRESPEXT  out  1  1 = ERROR

Behaviour:
- Accept condition: HSELEXT & HREADY & HTRANS[1] (NONSEQ/SEQ).
  - On accept, register address, write flag, size and an error flag.
  - Error flag = HADDR outside [BASE, BASE+DEPTH*AHBW/8) or HSIZE > log2(AHBW/8).
- Word index = (HADDR-BASE) >> log2(AHBW/8), truncated to log2(DEPTH) bits.
- IDLE/BUSY transfers and unselected cycles: no data phase; HREADYEXT=1, HRESPEXT=0.
- FSM states:
  - IDLE
  - WAIT (counter from WAIT_CYCLES down to 0)
  - DATA
  - ERR1
  - ERR2
- Transitions:
  - IDLE on accept → WAIT if WAIT_CYCLES>0, else DATA.
  - If the error flag is set → ERR1 instead, bypassing waits.
  - WAIT → DATA when counter reaches 1.
  - ERR1 → ERR2.
  - DATA/ERR2 → DATA/WAIT/ERR1 on back-to-back accept in the same cycle, else IDLE.
- Outputs per state:
  - WAIT: HREADYEXT=0, HRESPEXT=0.
  - DATA: HREADYEXT=1, HRESPEXT=0.
  - ERR1: HREADYEXT=0, HRESPEXT=1.
  - ERR2: HREADYEXT=1, HRESPEXT=1.
- Write: in DATA, RAM word written at the clock edge, byte lanes enabled by HWSTRB. Errored writes never modify RAM.
- Read: in DATA, HRDATAEXT = RAM[index] combinationally from the registered index. HRDATAEXT=0 in every other state.
- Read-after-write to the same word, back-to-back, returns the new data; the write commits at the edge ending its data phase.
- Latency: OKAY transfer completes WAIT_CYCLES+1 cycles after the accept edge; ERROR completes in 2 cycles.
- Reset values: state IDLE, HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0, wait counter 0.
  - RAM contents are not reset.
  - Reset asserted mid-transfer abandons it; no partial write.

Optional Feature:
- Macro: AHB_EXT_LFSR_WAIT_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances once per accepted transfer.
  - LFSR[1:0] adds 0..3 extra wait states to each OKAY transfer. Errors are unaffected.
- When undefined: wait count is exactly WAIT_CYCLES; no LFSR flops exist.

Decomposition:
- Shared package holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - The responder state enum type.
  - The LFSR seed constant.
- One sub-module: ahb_ext_ram, a DEPTH×AHBW array with a byte-strobe write port and an asynchronous read port.

Test Plan:
- WAIT_CYCLES=0, write 64'hDEAD_BEEF_0123_4567 at BASE, HWSTRB=8'hFF, then read BASE → HREADYEXT never low; read returns the written value one cycle after the read accept.
- WAIT_CYCLES=3, single read at BASE+8 → HREADYEXT low for exactly 3 cycles, then high with data; HRESPEXT=0 throughout.
- Write 64'h0, then write 64'hFFFF_FFFF_FFFF_FFFF with HWSTRB=8'h0F at BASE+16, read back → 64'h0000_0000_FFFF_FFFF.
- Read at BASE+DEPTH*8 (out of window) → cycle 1: HREADYEXT=0/HRESPEXT=1; cycle 2: HREADYEXT=1/HRESPEXT=1; HRDATAEXT=0; a following errored write leaves RAM unchanged.
- Back-to-back NONSEQ write then read of the same word, WAIT_CYCLES=0 → the read returns the new data; no bubble between the data phases.
- Assert reset during the WAIT state of a write → HREADYEXT=1, HRESPEXT=0 immediately; later read of that word shows the old contents. With AHB_EXT_LFSR_WAIT_EN defined, the first three transfers after reset show the deterministic wait counts derived from seed 8'hA5.
